tetris_move_ctrl: RTL
=====================

Name: tetris_move_ctrl

Overview:
- Sequencer for the active falling piece.
- Latches player move requests (left/right/rotate/soft-drop) and gravity ticks, then serves them one at a time in a fixed priority order.
- For each request it selects the matching collision checker (left/right/down/rotate), samples that checker's stop result, and either commits the move to the piece reference registers or, for a blocked down move, locks the piece.
- Sits between the input debouncers and gravity timer on one side, and the collision checkers, grid writer and renderer on the other.

Parameters:
- SIZE, 16: block edge in pixels; step size of one left, right or down move.
- X_SPAWN, 304: ref_x loaded at spawn.
- Y_SPAWN, 0: ref_y loaded at spawn.
- SETTLE, 1: cycles to wait after driving check_sel before sampling stop_*; legal range 1 to 3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- game_en  in  1  run enable; 0 freezes the FSM in IDLE and keeps pending requests.
- req_left  in  1  one-cycle request pulse.
- req_right  in  1  one-cycle request pulse.
- req_rot  in  1  one-cycle request pulse.
- req_down  in  1  one-cycle request pulse (soft drop).
- grav_tick  in  1  one-cycle gravity pulse.
- stop_left  in  1  collision result, left checker.
- stop_right  in  1  collision result, right checker.
- stop_down  in  1  collision result, down checker.
- stop_rot  in  1  collision result, rotate checker.
- clr_done  in  1  pulse from line-clear engine after a lock has been merged.
- check_sel  out  3  0=none, 1=left, 2=right, 3=down, 4=rotate; selects the checker under evaluation.
- ref_x  out  10  piece x in pixels.
- ref_y  out  10  piece y in pixels.
- rot  out  2  rotation index.
- lock_pulse  out  1  one cycle: write piece into grid.
- spawn_pulse  out  1  one cycle: new piece loaded.
- busy  out  1  FSM not in IDLE.
- game_over  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values: ref_x=X_SPAWN, ref_y=Y_SPAWN, rot=0, check_sel=0, all pulses 0, busy=0, game_over=0, all pending bits 0, FSM=IDLE.
- Pending latches:
  - Four bits: P_DOWN (set by req_down or grav_tick), P_ROT, P_LEFT, P_RIGHT.
  - A request pulse sets its bit on any cycle, including while busy.
  - A bit clears in the cycle its request is committed or rejected.
  - A set and a clear of the same bit in the same cycle leave it set, so the new request is kept.
  - Repeated pulses while a bit is already set merge into that one bit.
- Priority: DOWN > ROT > LEFT > RIGHT.
- States:
  - IDLE: busy=0, check_sel=0. If game_en and any pending bit is set, latch the winner into cur, drive check_sel, clear the settle counter, go to EVAL.
  - EVAL: hold check_sel for SETTLE cycles, then sample the stop input for cur and go to ACT.
  - ACT: exactly one cycle, then back to IDLE unless stated otherwise.
    - left not stopped: ref_x -= SIZE.
    - right not stopped: ref_x += SIZE.
    - rotate not stopped: rot += 1, wrapping 3 to 0.
    - down not stopped: ref_y += SIZE.
    - Any stopped left, right or rotate: no change.
    - Stopped down: assert lock_pulse, go to WAIT_CLR.
    - In every case the pending bit for cur clears.
  - WAIT_CLR:
    - Hold busy=1 and check_sel=0 until clr_done, then go to SPAWN.
    - ROT, LEFT and RIGHT pending bits clear on entry (stale player input).
    - P_DOWN is kept.
  - SPAWN:
    - Load ref_x=X_SPAWN, ref_y=Y_SPAWN, rot=0; pulse spawn_pulse; go to SPCHK.
  - SPCHK:
    - Drive check_sel=3 for SETTLE cycles, then sample stop_down.
    - stop_down=1: set game_over, go to OVER.
    - stop_down=0: go to IDLE.
  - OVER: terminal. busy=1, check_sel=0, requests ignored; exit only by reset.
- Timing:
  - Latency from request pulse in IDLE to committed position change is SETTLE+2 cycles.
  - ref_x, ref_y and rot are stable during EVAL; checkers see constant inputs while evaluated.
- Arithmetic: 10-bit unsigned. Wall and floor limits are the checkers' job; this block never clamps.
- game_en=0 mid-operation: the current evaluation completes and the FSM returns to IDLE, then holds there.
- Asynchronous reset mid-operation returns every register to its reset value immediately.

Test Plan:
- Left, free path: reset, SETTLE=1, req_left with stop_left=0. Expect check_sel=1 for 1 cycle, ref_x 304 to 288 exactly 3 cycles after the pulse, busy then 0.
- Blocked right: req_right with stop_right=1. Expect ref_x unchanged, P_RIGHT cleared, no lock_pulse.
- Priority: req_left, req_rot and grav_tick in the same cycle, all stops 0. Expect service order down (ref_y 0 to 16), then rot (0 to 1), then left (ref_x to 288).
- Lock and spawn: grav_tick with stop_down=1. Expect lock_pulse for 1 cycle; req_left during WAIT_CLR is dropped. clr_done then gives spawn_pulse with ref_x=304, ref_y=0, rot=0.
- Game over: hold stop_down=1 through SPCHK. Expect game_over=1 and busy=1; further requests have no effect until rst_n low, after which all outputs are at reset values.
- Rotate wrap and merge: 4 req_rot serviced, with a 5th pulse arriving while P_ROT is still set. Expect rot sequence 1, 2, 3, 0 with the 5th merged and not serviced separately.

Source files
------------

// File: rtl/tetris_move_ctrl.sv
// Active-piece sequencer: latches move/gravity requests, serves them one at a time
// through the collision checkers, then commits the move or locks and respawns the piece.
module tetris_move_ctrl #(
   parameter int SIZE    = 16,
   parameter int X_SPAWN = 304,
   parameter int Y_SPAWN = 0,
   parameter int SETTLE  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       game_en,
   input  logic       req_left,
   input  logic       req_right,
   input  logic       req_rot,
   input  logic       req_down,
   input  logic       grav_tick,
   input  logic       stop_left,
   input  logic       stop_right,
   input  logic       stop_down,
   input  logic       stop_rot,
   input  logic       clr_done,
   output logic [2:0] check_sel,
   output logic [9:0] ref_x,
   output logic [9:0] ref_y,
   output logic [1:0] rot,
   output logic       lock_pulse,
   output logic       spawn_pulse,
   output logic       busy,
   output logic       game_over
);

   typedef enum logic [2:0] {
      S_IDLE, S_EVAL, S_ACT, S_WAIT_CLR, S_SPAWN, S_SPCHK, S_OVER
   } state_t;

   // Values double as bit positions in the pending vector, lowest index wins.
   typedef enum logic [1:0] {C_DOWN, C_ROT, C_LEFT, C_RIGHT} cmd_t;

   localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

   state_t     state, state_nx;
   cmd_t       cur, cur_nx;
   logic [1:0] cnt, cnt_nx;
   logic       stop_q, stop_nx;
   logic [3:0] pend, pend_nx, pend_eff, req_vec, pend_clr;
   logic       pend_drop;
   logic [9:0] x_nx, y_nx;
   logic [1:0] rot_nx;
   logic       go_nx;
   logic       stop_mux;

   function automatic logic [2:0] sel_code(input cmd_t c);
      case (c)
         C_LEFT:  return 3'd1;
         C_RIGHT: return 3'd2;
         C_DOWN:  return 3'd3;
         default: return 3'd4;
      endcase
   endfunction

   assign req_vec  = {req_right, req_left, req_rot, req_down | grav_tick};
   // Same-cycle requests are visible to IDLE so the request-to-commit latency is SETTLE+2.
   assign pend_eff = pend | req_vec;
   assign busy     = (state != S_IDLE);

   always_comb begin
      case (cur)
         C_LEFT:  stop_mux = stop_left;
         C_RIGHT: stop_mux = stop_right;
         C_DOWN:  stop_mux = stop_down;
         default: stop_mux = stop_rot;
      endcase
   end

   always_comb begin
      state_nx    = state;
      cur_nx      = cur;
      cnt_nx      = cnt;
      stop_nx     = stop_q;
      pend_clr    = 4'b0000;
      pend_drop   = 1'b0;
      x_nx        = ref_x;
      y_nx        = ref_y;
      rot_nx      = rot;
      go_nx       = game_over;
      check_sel   = 3'd0;
      lock_pulse  = 1'b0;
      spawn_pulse = 1'b0;

      case (state)
         S_IDLE: begin
            if (game_en && |pend_eff) begin
               state_nx = S_EVAL;
               cnt_nx   = 2'd0;
               if (pend_eff[0])      cur_nx = C_DOWN;
               else if (pend_eff[1]) cur_nx = C_ROT;
               else if (pend_eff[2]) cur_nx = C_LEFT;
               else                  cur_nx = C_RIGHT;
            end
         end
         S_EVAL: begin
            check_sel = sel_code(cur);
            if (cnt == SETTLE_LAST) begin
               stop_nx  = stop_mux;
               state_nx = S_ACT;
            end else begin
               cnt_nx = cnt + 2'd1;
            end
         end
         S_ACT: begin
            pend_clr = 4'b0001 << cur;
            state_nx = S_IDLE;
            case (cur)
               C_LEFT:  if (!stop_q) x_nx = ref_x - 10'(SIZE);
               C_RIGHT: if (!stop_q) x_nx = ref_x + 10'(SIZE);
               C_ROT:   if (!stop_q) rot_nx = rot + 2'd1;
               default: begin
                  if (stop_q) begin
                     lock_pulse = 1'b1;
                     pend_drop  = 1'b1;
                     state_nx   = S_WAIT_CLR;
                  end else begin
                     y_nx = ref_y + 10'(SIZE);
                  end
               end
            endcase
         end
         S_WAIT_CLR: begin
            pend_drop = 1'b1;
            // Load spawn coordinates on the way in so they are valid during spawn_pulse.
            if (clr_done) begin
               state_nx = S_SPAWN;
               x_nx     = 10'(X_SPAWN);
               y_nx     = 10'(Y_SPAWN);
               rot_nx   = 2'd0;
            end
         end
         S_SPAWN: begin
            spawn_pulse = 1'b1;
            cnt_nx      = 2'd0;
            state_nx    = S_SPCHK;
         end
         S_SPCHK: begin
            check_sel = 3'd3;
            if (cnt == SETTLE_LAST) begin
               if (stop_down) begin
                  go_nx    = 1'b1;
                  state_nx = S_OVER;
               end else begin
                  state_nx = S_IDLE;
               end
            end else begin
               cnt_nx = cnt + 2'd1;
            end
         end
         default: ;
      endcase

      // A new request in the clear cycle wins; OVER ignores everything.
      pend_nx = (pend & ~pend_clr) | ((state == S_OVER) ? 4'b0000 : req_vec);
      if (pend_drop) pend_nx[3:1] = 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cur       <= C_DOWN;
         cnt       <= 2'd0;
         stop_q    <= 1'b0;
         pend      <= 4'b0000;
         ref_x     <= 10'(X_SPAWN);
         ref_y     <= 10'(Y_SPAWN);
         rot       <= 2'd0;
         game_over <= 1'b0;
      end else begin
         state     <= state_nx;
         cur       <= cur_nx;
         cnt       <= cnt_nx;
         stop_q    <= stop_nx;
         pend      <= pend_nx;
         ref_x     <= x_nx;
         ref_y     <= y_nx;
         rot       <= rot_nx;
         game_over <= go_nx;
      end
   end

endmodule
